// File: rtl/decode_stage.sv
// Registered RV32I/RV64I instruction-decode stage with valid/ready handshake,
// flush, a RUN/HALT state machine and an accepted-instruction counter.
module decode_stage #(
   parameter int XLEN      = 64,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_inst,
   input  logic [XLEN-1:0]      in_pc,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [31:0]          out_inst,
   output logic                 reg_wen,
   output logic [4:0]           reg_waddr,
   output logic [4:0]           reg1_raddr,
   output logic [4:0]           reg2_raddr,
   output logic [2:0]           imm_sel,
   output logic [3:0]           alu_op,
   output logic [1:0]           alu_src_sel,
   output logic                 branch,
   output logic                 jump,
   output logic                 jalr,
   output logic [2:0]           br_cond,
   output logic                 mem_ren,
   output logic                 mem_wen,
   output logic [1:0]           mem_size,
   output logic                 mem_unsigned,
   output logic                 word_op,
   output logic                 illegal,
   output logic                 ebreak,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] dec_count
);
   localparam bit RV64 = (XLEN == 64);

   localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                          ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
   localparam logic [1:0] SRC_REG = 2'd0, SRC_IMM = 2'd1, SRC_FOUR_PC = 2'd2, SRC_IMM_PC = 2'd3;

   typedef struct packed {
      logic       wen;
      logic [4:0] waddr;
      logic [4:0] raddr1;
      logic [4:0] raddr2;
      logic [2:0] imm_sel;
      logic [3:0] alu_op;
      logic [1:0] src_sel;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic [2:0] br_cond;
      logic       mem_ren;
      logic       mem_wen;
      logic [1:0] mem_size;
      logic       mem_unsigned;
      logic       word_op;
      logic       illegal;
      logic       ebreak;
   } bundle_t;

   typedef enum logic {RUN, HALT} state_t;

   state_t                state_reg;
   logic                  valid_reg;
   bundle_t               bundle_reg;
   bundle_t               dec;
   logic [XLEN-1:0]       pc_reg;
   logic [31:0]           inst_reg;
   logic [CNT_WIDTH-1:0]  count_reg;
   logic                  accept;
   logic                  bad;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [5:0] funct6;
   logic [4:0] rd, rs1, rs2;
   logic       shift_ok, op_ok;

   assign opcode = in_inst[6:0];
   assign rd     = in_inst[11:7];
   assign funct3 = in_inst[14:12];
   assign rs1    = in_inst[19:15];
   assign rs2    = in_inst[24:20];
   assign funct7 = in_inst[31:25];
   assign funct6 = in_inst[31:26];

   // Immediate shifts: 6-bit shamt on RV64 leaves funct6 as the qualifier.
   assign shift_ok = RV64 ? (funct6 == 6'b000000 || (funct3 == 3'd5 && funct6 == 6'b010000))
                          : (funct7 == 7'h00 || (funct3 == 3'd5 && funct7 == 7'h20));
   assign op_ok    = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));

   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
         3'd1:    alu_of = ALU_SLL;
         3'd2:    alu_of = ALU_SLT;
         3'd3:    alu_of = ALU_SLTU;
         3'd4:    alu_of = ALU_XOR;
         3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
         3'd6:    alu_of = ALU_OR;
         default: alu_of = ALU_AND;
      endcase
   endfunction

   always_comb begin
      dec = '0;
      bad = 1'b0;
      case (opcode)
         7'h37: begin dec.wen = 1'b1; dec.waddr = rd; dec.imm_sel = IMM_U; dec.src_sel = SRC_IMM; end
         7'h17: begin dec.wen = 1'b1; dec.waddr = rd; dec.imm_sel = IMM_U; dec.src_sel = SRC_IMM_PC; end
         7'h6F: begin
            dec.wen = 1'b1; dec.waddr = rd; dec.imm_sel = IMM_J;
            dec.src_sel = SRC_FOUR_PC; dec.jump = 1'b1;
         end
         7'h67: begin
            bad = (funct3 != 3'd0);
            dec.wen = 1'b1; dec.waddr = rd; dec.raddr1 = rs1; dec.imm_sel = IMM_I;
            dec.src_sel = SRC_FOUR_PC; dec.jump = 1'b1; dec.jalr = 1'b1;
         end
         7'h63: begin
            bad = (funct3 == 3'd2 || funct3 == 3'd3);
            dec.raddr1 = rs1; dec.raddr2 = rs2; dec.imm_sel = IMM_B; dec.alu_op = ALU_SUB;
            dec.src_sel = SRC_REG; dec.branch = 1'b1; dec.br_cond = funct3;
         end
         7'h03: begin
            bad = (funct3 == 3'd7) || (!RV64 && (funct3 == 3'd3 || funct3 == 3'd6));
            dec.wen = 1'b1; dec.waddr = rd; dec.raddr1 = rs1; dec.imm_sel = IMM_I;
            dec.src_sel = SRC_IMM; dec.mem_ren = 1'b1;
            dec.mem_size = funct3[1:0]; dec.mem_unsigned = funct3[2];
         end
         7'h23: begin
            bad = funct3[2] || (!RV64 && funct3 == 3'd3);
            dec.raddr1 = rs1; dec.raddr2 = rs2; dec.imm_sel = IMM_S;
            dec.src_sel = SRC_IMM; dec.mem_wen = 1'b1; dec.mem_size = funct3[1:0];
         end
         7'h13: begin
            bad = (funct3 == 3'd1 || funct3 == 3'd5) && !shift_ok;
            dec.wen = 1'b1; dec.waddr = rd; dec.raddr1 = rs1; dec.imm_sel = IMM_I;
            dec.src_sel = SRC_IMM; dec.alu_op = alu_of(funct3, funct3 == 3'd5 && in_inst[30]);
         end
         7'h33: begin
            bad = !op_ok;
            dec.wen = 1'b1; dec.waddr = rd; dec.raddr1 = rs1; dec.raddr2 = rs2;
            dec.src_sel = SRC_REG; dec.alu_op = alu_of(funct3, in_inst[30]);
         end
         7'h1B: begin
            bad = !RV64 || !(funct3 == 3'd0 || ((funct3 == 3'd1 || funct3 == 3'd5) && op_ok));
            dec.wen = 1'b1; dec.waddr = rd; dec.raddr1 = rs1; dec.imm_sel = IMM_I;
            dec.src_sel = SRC_IMM; dec.word_op = 1'b1;
            dec.alu_op = alu_of(funct3, funct3 == 3'd5 && in_inst[30]);
         end
         7'h3B: begin
            bad = !RV64 || !op_ok || !(funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd5);
            dec.wen = 1'b1; dec.waddr = rd; dec.raddr1 = rs1; dec.raddr2 = rs2;
            dec.src_sel = SRC_REG; dec.word_op = 1'b1; dec.alu_op = alu_of(funct3, in_inst[30]);
         end
         7'h0F: bad = (funct3 != 3'd0);
         7'h73: begin
            if (in_inst == 32'h0010_0073) dec.ebreak = 1'b1;
            else bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      // An illegal bundle carries no side effects at all.
      if (bad) begin
         dec = '0;
         dec.illegal = 1'b1;
      end
      if (dec.waddr == 5'd0) dec.wen = 1'b0;
   end

   assign in_ready = (state_reg == RUN) && (!valid_reg || out_ready);
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= RUN;
         valid_reg  <= 1'b0;
         bundle_reg <= '0;
         pc_reg     <= '0;
         inst_reg   <= '0;
         count_reg  <= '0;
      end else begin
         if (accept) begin
            bundle_reg <= dec;
            pc_reg     <= in_pc;
            inst_reg   <= in_inst;
            count_reg  <= count_reg + CNT_WIDTH'(1);
            if (dec.illegal || dec.ebreak) state_reg <= HALT;
         end
         if (flush)          valid_reg <= 1'b0;
         else if (accept)    valid_reg <= 1'b1;
         else if (out_ready) valid_reg <= 1'b0;
      end
   end

   assign out_valid    = valid_reg;
   assign out_pc       = pc_reg;
   assign out_inst     = inst_reg;
   assign reg_wen      = bundle_reg.wen;
   assign reg_waddr    = bundle_reg.waddr;
   assign reg1_raddr   = bundle_reg.raddr1;
   assign reg2_raddr   = bundle_reg.raddr2;
   assign imm_sel      = bundle_reg.imm_sel;
   assign alu_op       = bundle_reg.alu_op;
   assign alu_src_sel  = bundle_reg.src_sel;
   assign branch       = bundle_reg.branch;
   assign jump         = bundle_reg.jump;
   assign jalr         = bundle_reg.jalr;
   assign br_cond      = bundle_reg.br_cond;
   assign mem_ren      = bundle_reg.mem_ren;
   assign mem_wen      = bundle_reg.mem_wen;
   assign mem_size     = bundle_reg.mem_size;
   assign mem_unsigned = bundle_reg.mem_unsigned;
   assign word_op      = bundle_reg.word_op;
   assign illegal      = bundle_reg.illegal;
   assign ebreak       = bundle_reg.ebreak;
   assign halted       = (state_reg == HALT);
   assign dec_count    = count_reg;
endmodule
